mux_rr_arbiter: RTL

Two-requester round-robin arbiter that time-shares a single 2:1 data mux (din_0/din_1 -> mux_out) between independent sources. It owns the mux select, grants one requester at a time with a valid/ready-style handshake, and registers the selected data into a one-entry output stage. It sits between two producers and one downstream consumer.

---
 rtl/mux_arb_pkg.sv | 13 +
 rtl/mux_arb_out_stage.sv | 33 +++
 rtl/mux_rr_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and default sizing for the two-requester round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/mux_arb_out_stage.sv
// One-entry output register: load wins over pop, so a pop and a load in the
// same cycle replace the held beat without a bubble.
module mux_arb_out_stage
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_sel,
  input  logic [DATA_W-1:0] load_data,
  input  logic              pop,
  output logic              sel,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      sel   <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      sel   <= load_sel;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning a 2:1 data mux with a registered output stage.
// Optional burst cap on locked grants: define MUX_ARB_BURST_LIMIT_EN.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              lock_0,
  input  logic              lock_1,
  input  logic [DATA_W-1:0] din_0,
  input  logic [DATA_W-1:0] din_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              sel,
  output logic [DATA_W-1:0] mux_out,
  output logic              out_valid,
  input  logic              out_ready
);

  arb_state_e state, state_nxt;
  logic       last;
  logic       space, side, req_g, lock_g, acc, limit;

  // Tie goes to the requester that did not win most recently.
  function automatic arb_state_e pick(input logic r0, input logic r1, input logic lst);
    if (r0 && r1) return lst ? GRANT0 : GRANT1;
    else if (r0)  return GRANT0;
    else if (r1)  return GRANT1;
    else          return IDLE;
  endfunction

  assign space  = !out_valid || out_ready;
  assign gnt_0  = !rst && (state == GRANT0) && space;
  assign gnt_1  = !rst && (state == GRANT1) && space;
  assign side   = (state == GRANT1);
  assign req_g  = side ? req_1 : req_0;
  assign lock_g = side ? lock_1 : lock_0;
  assign acc    = (gnt_0 && req_0) || (gnt_1 && req_1);

`ifdef MUX_ARB_BURST_LIMIT_EN
  localparam int CNT_W = ($clog2(MAX_BURST + 1) > 3) ? $clog2(MAX_BURST + 1) : 3;
  logic [CNT_W-1:0] cnt;

  assign limit = (cnt == CNT_W'(MAX_BURST - 1));
`else
  assign limit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = pick(req_0, req_1, last);
      GRANT0, GRANT1: begin
        if (acc)
          state_nxt = (lock_g && !limit) ? state : pick(req_0, req_1, side);
        else if (!req_g)
          state_nxt = pick(req_0, req_1, last);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (acc) last <= side;
    end
  end

`ifdef MUX_ARB_BURST_LIMIT_EN
  // Count restarts on a grant change or when the cap is reached while kept.
  always_ff @(posedge clk) begin
    if (rst)                    cnt <= '0;
    else if (state_nxt != state) cnt <= '0;
    else if (acc)               cnt <= limit ? '0 : cnt + 1'b1;
  end
`endif

  mux_arb_out_stage #(.DATA_W(DATA_W)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (acc),
    .load_sel  (side),
    .load_data (side ? din_1 : din_0),
    .pop       (out_ready),
    .sel       (sel),
    .data      (mux_out),
    .valid     (out_valid)
  );

endmodule
